// File: rtl/marker_locate.sv
// Colour-marker locator: classifies RGB565 pixels, tracks the extreme points of the matching
// region over a frame and publishes registered corner/centre positions once per frame.
module marker_locate #(
    parameter logic [4:0]  THR_R   = 5'd20,
    parameter logic [5:0]  THR_G   = 6'd24,
    parameter logic [4:0]  THR_B   = 5'd12,
    parameter logic [15:0] MIN_PIX = 16'd64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_vs,
    input  logic        pix_hs,
    input  logic        pix_de,
    input  logic [15:0] pix_data,
    input  logic        hold,
    output logic [9:0]  top_pos_x,
    output logic [9:0]  top_pos_y,
    output logic [9:0]  bottom_pos_x,
    output logic [9:0]  bottom_pos_y,
    output logic [9:0]  left_pos_x,
    output logic [9:0]  left_pos_y,
    output logic [9:0]  right_pos_x,
    output logic [9:0]  right_pos_y,
    output logic [11:0] centre_pos_x,
    output logic [11:0] centre_pos_y,
    output logic        obj_valid,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2,
        WAIT   = 2'd3
    } state_t;

    function automatic logic pix_is_marker(input logic [15:0] px);
        pix_is_marker = (px[15:11] >= THR_R) && (px[10:5] < THR_G) && (px[4:0] < THR_B);
    endfunction

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        if (v == 10'd1023) begin
            sat_inc10 = v;
        end else begin
            sat_inc10 = v + 10'd1;
        end
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            sat_inc16 = v;
        end else begin
            sat_inc16 = v + 16'd1;
        end
    endfunction

    // sync history and raster coordinates
    logic       vs_q, vs_qq, hs_q, hs_qq;
    logic       vs_d, vs_dd, hs_d, hs_dd;
    logic [9:0] x_q, x_d, y_q, y_d;
    // stage S1
    logic       s1_match_q, s1_match_d;
    logic [9:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;
    // frame accumulators
    state_t     state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic       found_q, found_d;
    logic [9:0] top_x_q, top_x_d, top_y_q, top_y_d;
    logic [9:0] bot_x_q, bot_x_d, bot_y_q, bot_y_d;
    logic [9:0] left_x_q, left_x_d, left_y_q, left_y_d;
    logic [9:0] right_x_q, right_x_d, right_y_q, right_y_d;
    // published results
    logic [9:0]  top_pos_x_q, top_pos_x_d, top_pos_y_q, top_pos_y_d;
    logic [9:0]  bottom_pos_x_q, bottom_pos_x_d, bottom_pos_y_q, bottom_pos_y_d;
    logic [9:0]  left_pos_x_q, left_pos_x_d, left_pos_y_q, left_pos_y_d;
    logic [9:0]  right_pos_x_q, right_pos_x_d, right_pos_y_q, right_pos_y_d;
    logic [11:0] centre_pos_x_q, centre_pos_x_d, centre_pos_y_q, centre_pos_y_d;
    logic        obj_valid_q, obj_valid_d, frame_done_q, frame_done_d;

    logic        vs_rise_s, vs_fall_s, hs_fall_s, pix_vld_s;
    logic [10:0] sum_x_s, sum_y_s;

    assign vs_rise_s = vs_q & ~vs_qq;
    assign vs_fall_s = ~vs_q & vs_qq;
    assign hs_fall_s = ~hs_q & hs_qq;
    assign pix_vld_s = pix_hs & pix_de;
    assign sum_x_s   = {1'b0, left_x_q} + {1'b0, right_x_q};
    assign sum_y_s   = {1'b0, top_y_q} + {1'b0, bot_y_q};

    // Sync edge history, saturating x/y counters and the S1 classification stage
    always_comb begin
        vs_d  = pix_vs;
        vs_dd = vs_q;
        hs_d  = pix_hs;
        hs_dd = hs_q;
        if (!pix_hs) begin
            x_d = 10'd0;
        end else if (pix_de) begin
            x_d = sat_inc10(x_q);
        end else begin
            x_d = x_q;
        end
        if (vs_fall_s) begin
            y_d = 10'd0;
        end else if (hs_fall_s) begin
            y_d = sat_inc10(y_q);
        end else begin
            y_d = y_q;
        end
        s1_match_d = pix_vld_s & pix_is_marker(pix_data);
        s1_x_d     = x_q;
        s1_y_d     = y_q;
    end

    // Extreme-point accumulation from S1; cleared whenever the frame is not being scanned
    always_comb begin
        cnt_d     = cnt_q;
        found_d   = found_q;
        top_x_d   = top_x_q;
        top_y_d   = top_y_q;
        bot_x_d   = bot_x_q;
        bot_y_d   = bot_y_q;
        left_x_d  = left_x_q;
        left_y_d  = left_y_q;
        right_x_d = right_x_q;
        right_y_d = right_y_q;
        if (state_q != SCAN) begin
            cnt_d     = 16'd0;
            found_d   = 1'b0;
            top_x_d   = 10'd0;
            top_y_d   = 10'd0;
            bot_x_d   = 10'd0;
            bot_y_d   = 10'd0;
            left_x_d  = 10'd0;
            left_y_d  = 10'd0;
            right_x_d = 10'd0;
            right_y_d = 10'd0;
        end else if (s1_match_q) begin
            cnt_d   = sat_inc16(cnt_q);
            bot_x_d = s1_x_q;
            bot_y_d = s1_y_q;
            if (!found_q) begin
                found_d   = 1'b1;
                top_x_d   = s1_x_q;
                top_y_d   = s1_y_q;
                left_x_d  = s1_x_q;
                left_y_d  = s1_y_q;
                right_x_d = s1_x_q;
                right_y_d = s1_y_q;
            end else begin
                // strict compares keep the earliest row on ties
                if (s1_x_q < left_x_q) begin
                    left_x_d = s1_x_q;
                    left_y_d = s1_y_q;
                end else begin
                    left_x_d = left_x_q;
                    left_y_d = left_y_q;
                end
                if (s1_x_q > right_x_q) begin
                    right_x_d = s1_x_q;
                    right_y_d = s1_y_q;
                end else begin
                    right_x_d = right_x_q;
                    right_y_d = right_y_q;
                end
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Frame sequencing and result publication
    always_comb begin
        state_d        = state_q;
        frame_done_d   = 1'b0;
        obj_valid_d    = obj_valid_q;
        top_pos_x_d    = top_pos_x_q;
        top_pos_y_d    = top_pos_y_q;
        bottom_pos_x_d = bottom_pos_x_q;
        bottom_pos_y_d = bottom_pos_y_q;
        left_pos_x_d   = left_pos_x_q;
        left_pos_y_d   = left_pos_y_q;
        right_pos_x_d  = right_pos_x_q;
        right_pos_y_d  = right_pos_y_q;
        centre_pos_x_d = centre_pos_x_q;
        centre_pos_y_d = centre_pos_y_q;
        case (state_q)
            IDLE: begin
                if (vs_fall_s) begin
                    state_d = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (vs_rise_s) begin
                    state_d = COMMIT;
                end else begin
                    state_d = SCAN;
                end
            end
            COMMIT: begin
                state_d = WAIT;
                if (!hold) begin
                    frame_done_d = 1'b1;
                    if (cnt_q >= MIN_PIX) begin
                        obj_valid_d    = 1'b1;
                        top_pos_x_d    = top_x_q;
                        top_pos_y_d    = top_y_q;
                        bottom_pos_x_d = bot_x_q;
                        bottom_pos_y_d = bot_y_q;
                        left_pos_x_d   = left_x_q;
                        left_pos_y_d   = left_y_q;
                        right_pos_x_d  = right_x_q;
                        right_pos_y_d  = right_y_q;
                        centre_pos_x_d = {1'b0, sum_x_s >> 1};
                        centre_pos_y_d = {1'b0, sum_y_s >> 1};
                    end else begin
                        obj_valid_d = 1'b0;
                    end
                end else begin
                    frame_done_d = 1'b0;
                end
            end
            WAIT: begin
                if (vs_fall_s) begin
                    state_d = SCAN;
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register for the whole block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q           <= 1'b0;
            vs_qq          <= 1'b0;
            hs_q           <= 1'b0;
            hs_qq          <= 1'b0;
            x_q            <= 10'd0;
            y_q            <= 10'd0;
            s1_match_q     <= 1'b0;
            s1_x_q         <= 10'd0;
            s1_y_q         <= 10'd0;
            state_q        <= IDLE;
            cnt_q          <= 16'd0;
            found_q        <= 1'b0;
            top_x_q        <= 10'd0;
            top_y_q        <= 10'd0;
            bot_x_q        <= 10'd0;
            bot_y_q        <= 10'd0;
            left_x_q       <= 10'd0;
            left_y_q       <= 10'd0;
            right_x_q      <= 10'd0;
            right_y_q      <= 10'd0;
            top_pos_x_q    <= 10'd0;
            top_pos_y_q    <= 10'd0;
            bottom_pos_x_q <= 10'd0;
            bottom_pos_y_q <= 10'd0;
            left_pos_x_q   <= 10'd0;
            left_pos_y_q   <= 10'd0;
            right_pos_x_q  <= 10'd0;
            right_pos_y_q  <= 10'd0;
            centre_pos_x_q <= 12'd0;
            centre_pos_y_q <= 12'd0;
            obj_valid_q    <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            vs_q           <= vs_d;
            vs_qq          <= vs_dd;
            hs_q           <= hs_d;
            hs_qq          <= hs_dd;
            x_q            <= x_d;
            y_q            <= y_d;
            s1_match_q     <= s1_match_d;
            s1_x_q         <= s1_x_d;
            s1_y_q         <= s1_y_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            found_q        <= found_d;
            top_x_q        <= top_x_d;
            top_y_q        <= top_y_d;
            bot_x_q        <= bot_x_d;
            bot_y_q        <= bot_y_d;
            left_x_q       <= left_x_d;
            left_y_q       <= left_y_d;
            right_x_q      <= right_x_d;
            right_y_q      <= right_y_d;
            top_pos_x_q    <= top_pos_x_d;
            top_pos_y_q    <= top_pos_y_d;
            bottom_pos_x_q <= bottom_pos_x_d;
            bottom_pos_y_q <= bottom_pos_y_d;
            left_pos_x_q   <= left_pos_x_d;
            left_pos_y_q   <= left_pos_y_d;
            right_pos_x_q  <= right_pos_x_d;
            right_pos_y_q  <= right_pos_y_d;
            centre_pos_x_q <= centre_pos_x_d;
            centre_pos_y_q <= centre_pos_y_d;
            obj_valid_q    <= obj_valid_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign top_pos_x    = top_pos_x_q;
    assign top_pos_y    = top_pos_y_q;
    assign bottom_pos_x = bottom_pos_x_q;
    assign bottom_pos_y = bottom_pos_y_q;
    assign left_pos_x   = left_pos_x_q;
    assign left_pos_y   = left_pos_y_q;
    assign right_pos_x  = right_pos_x_q;
    assign right_pos_y  = right_pos_y_q;
    assign centre_pos_x = centre_pos_x_q;
    assign centre_pos_y = centre_pos_y_q;
    assign obj_valid    = obj_valid_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_marker_locate.sv
// Directed bench for marker_locate: short synthetic frames (empty lines carry no pixels)
// with hand-computed extreme points, centre, validity and frame_done timing.
module tb_marker_locate;

    logic        clk, rst_n, pix_vs, pix_hs, pix_de, hold;
    logic [15:0] pix_data;
    logic [9:0]  top_pos_x, top_pos_y, bottom_pos_x, bottom_pos_y;
    logic [9:0]  left_pos_x, left_pos_y, right_pos_x, right_pos_y;
    logic [11:0] centre_pos_x, centre_pos_y;
    logic        obj_valid, frame_done;

    int n_vec = 0;
    int n_err = 0;

    logic [9:0]   obs_pt [0:7];
    logic [105:0] all_outs;
    string pt_name [0:7] = '{"top_x", "top_y", "bottom_x", "bottom_y",
                             "left_x", "left_y", "right_x", "right_y"};

    marker_locate #(.MIN_PIX(16'd16)) dut (
        .clk(clk), .rst_n(rst_n), .pix_vs(pix_vs), .pix_hs(pix_hs), .pix_de(pix_de),
        .pix_data(pix_data), .hold(hold),
        .top_pos_x(top_pos_x), .top_pos_y(top_pos_y),
        .bottom_pos_x(bottom_pos_x), .bottom_pos_y(bottom_pos_y),
        .left_pos_x(left_pos_x), .left_pos_y(left_pos_y),
        .right_pos_x(right_pos_x), .right_pos_y(right_pos_y),
        .centre_pos_x(centre_pos_x), .centre_pos_y(centre_pos_y),
        .obj_valid(obj_valid), .frame_done(frame_done)
    );

    assign obs_pt[0] = top_pos_x;
    assign obs_pt[1] = top_pos_y;
    assign obs_pt[2] = bottom_pos_x;
    assign obs_pt[3] = bottom_pos_y;
    assign obs_pt[4] = left_pos_x;
    assign obs_pt[5] = left_pos_y;
    assign obs_pt[6] = right_pos_x;
    assign obs_pt[7] = right_pos_y;
    assign all_outs = {top_pos_x, top_pos_y, bottom_pos_x, bottom_pos_y, left_pos_x, left_pos_y,
                       right_pos_x, right_pos_y, centre_pos_x, centre_pos_y, obj_valid, frame_done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before the end of the run");
        $fatal(1, "watchdog");
    end

    // marker pixels sit exactly on the thresholds or well inside them
    function automatic logic [15:0] mk_data(input int i);
        if (i % 2 == 0) return {5'd20, 6'd23, 5'd11};
        else            return 16'hF800;
    endfunction

    // each background pixel misses exactly one threshold by one step
    function automatic logic [15:0] nm_data(input int i);
        case (i % 3)
            0:       return {5'd19, 6'd0, 5'd0};
            1:       return {5'd31, 6'd24, 5'd0};
            default: return {5'd31, 6'd0, 5'd12};
        endcase
    endfunction

    function automatic int line_w(input int scn, input int y);
        case (scn)
            0:       return (y >= 50 && y <= 53) ? 104 : 0;
            1:       return (y == 10 || y == 20 || y == 30 || y == 50) ? 341 : 0;
            2:       return (y == 5) ? 10 : 0;
            3:       return (y >= 200 && y <= 207) ? 208 : 0;
            4:       return (y == 0) ? 1100 : 0;
            default: return (y >= 250 && y <= 253) ? 14 : 0;
        endcase
    endfunction

    function automatic bit is_mk(input int scn, input int x, input int y);
        case (scn)
            0:       return x >= 100 && x <= 103;
            1:       return (y == 10 && x == 320) || (y == 20 && x >= 310 && x <= 321) ||
                            (y == 30 && (x == 300 || x == 340)) || (y == 50 && x == 320);
            2:       return 1'b1;
            3:       return x >= 200 && x <= 207;
            4:       return 1'b1;
            default: return x >= 10 && x <= 13;
        endcase
    endfunction

    task automatic send_line(input int scn, input int y);
        int w;
        w = line_w(scn, y);
        if (w == 0) begin
            @(negedge clk); pix_hs = 1'b1; pix_de = 1'b0;
        end else begin
            for (int i = 0; i < w; i++) begin
                if (i % 16 == 5) begin
                    @(negedge clk); pix_hs = 1'b1; pix_de = 1'b0; pix_data = mk_data(i);
                end
                @(negedge clk); pix_hs = 1'b1; pix_de = 1'b1;
                pix_data = is_mk(scn, i, y) ? mk_data(i) : nm_data(i);
            end
        end
        // stray qualifier with marker colour outside the line must be ignored
        @(negedge clk); pix_hs = 1'b0; pix_de = 1'b1; pix_data = mk_data(0);
        repeat (3) begin
            @(negedge clk); pix_hs = 1'b0; pix_de = 1'b0;
        end
    endtask

    task automatic start_frame();
        @(negedge clk); pix_vs = 1'b0; pix_hs = 1'b0; pix_de = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic end_frame(output int done_at, output int done_cnt);
        done_at  = 0;
        done_cnt = 0;
        @(negedge clk); pix_vs = 1'b1; pix_hs = 1'b0; pix_de = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                done_cnt++;
                if (done_at == 0) done_at = c;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pix_vs = 1'b1; pix_hs = 1'b0; pix_de = 1'b0; pix_data = 16'd0; hold = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (all_outs !== 106'd0) begin
            n_err++; $display("FAIL reset_outs got %h want 0", all_outs);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if (all_outs !== 106'd0) begin
            n_err++; $display("FAIL post_reset_outs got %h want 0", all_outs);
        end
    endtask

    task automatic test_square(input string tag);
        int exp_pt [8] = '{100, 50, 103, 53, 100, 50, 103, 50};
        int done_at, done_cnt;
        start_frame();
        for (int y = 0; y < 54; y++) send_line(0, y);
        n_vec++;
        if (obj_valid !== 1'b0) begin
            n_err++; $display("FAIL %s_pre_valid got %0b want 0", tag, obj_valid);
        end
        end_frame(done_at, done_cnt);
        n_vec++;
        if (done_at != 3 || done_cnt != 1) begin
            n_err++; $display("FAIL %s_done at=%0d cnt=%0d want at=3 cnt=1", tag, done_at, done_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (obs_pt[i] !== 10'(exp_pt[i])) begin
                n_err++; $display("FAIL %s_%s got %0d want %0d", tag, pt_name[i], obs_pt[i], exp_pt[i]);
            end
        end
        n_vec++;
        if (centre_pos_x !== 12'd101 || centre_pos_y !== 12'd51 || obj_valid !== 1'b1) begin
            n_err++; $display("FAIL %s_centre got (%0d,%0d) v=%0b want (101,51) v=1",
                              tag, centre_pos_x, centre_pos_y, obj_valid);
        end
    endtask

    task automatic test_diamond();
        int exp_pt [8] = '{320, 10, 320, 50, 300, 30, 340, 30};
        int done_at, done_cnt;
        start_frame();
        for (int y = 0; y < 51; y++) begin
            send_line(1, y);
            if (y == 25) begin
                n_vec++;
                if (top_pos_x !== 10'd100 || centre_pos_x !== 12'd101 || obj_valid !== 1'b1) begin
                    n_err++; $display("FAIL diamond_midframe_hold got top_x=%0d cx=%0d v=%0b want 100 101 1",
                                      top_pos_x, centre_pos_x, obj_valid);
                end
            end
        end
        end_frame(done_at, done_cnt);
        n_vec++;
        if (done_at != 3 || done_cnt != 1) begin
            n_err++; $display("FAIL diamond_done at=%0d cnt=%0d want at=3 cnt=1", done_at, done_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (obs_pt[i] !== 10'(exp_pt[i])) begin
                n_err++; $display("FAIL diamond_%s got %0d want %0d", pt_name[i], obs_pt[i], exp_pt[i]);
            end
        end
        n_vec++;
        if (centre_pos_x !== 12'd320 || centre_pos_y !== 12'd30 || obj_valid !== 1'b1) begin
            n_err++; $display("FAIL diamond_centre got (%0d,%0d) v=%0b want (320,30) v=1",
                              centre_pos_x, centre_pos_y, obj_valid);
        end
    endtask

    task automatic test_low_count();
        int exp_pt [8] = '{320, 10, 320, 50, 300, 30, 340, 30};
        int done_at, done_cnt;
        start_frame();
        for (int y = 0; y < 6; y++) send_line(2, y);
        end_frame(done_at, done_cnt);
        n_vec++;
        if (done_at != 3 || done_cnt != 1 || obj_valid !== 1'b0) begin
            n_err++; $display("FAIL low_count at=%0d cnt=%0d v=%0b want at=3 cnt=1 v=0",
                              done_at, done_cnt, obj_valid);
        end
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (obs_pt[i] !== 10'(exp_pt[i])) begin
                n_err++; $display("FAIL low_keep_%s got %0d want %0d", pt_name[i], obs_pt[i], exp_pt[i]);
            end
        end
        n_vec++;
        if (centre_pos_x !== 12'd320 || centre_pos_y !== 12'd30) begin
            n_err++; $display("FAIL low_keep_centre got (%0d,%0d) want (320,30)", centre_pos_x, centre_pos_y);
        end
    endtask

    task automatic test_hold();
        int keep_pt [8] = '{320, 10, 320, 50, 300, 30, 340, 30};
        int new_pt [8]  = '{200, 200, 207, 207, 200, 200, 207, 200};
        int done_at, done_cnt;
        hold = 1'b1;
        start_frame();
        for (int y = 0; y < 208; y++) send_line(3, y);
        end_frame(done_at, done_cnt);
        n_vec++;
        if (done_cnt != 0 || obj_valid !== 1'b0) begin
            n_err++; $display("FAIL hold_frame cnt=%0d v=%0b want cnt=0 v=0", done_cnt, obj_valid);
        end
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (obs_pt[i] !== 10'(keep_pt[i])) begin
                n_err++; $display("FAIL hold_keep_%s got %0d want %0d", pt_name[i], obs_pt[i], keep_pt[i]);
            end
        end
        hold = 1'b0;
        start_frame();
        for (int y = 0; y < 208; y++) send_line(3, y);
        end_frame(done_at, done_cnt);
        n_vec++;
        if (done_at != 3 || done_cnt != 1 || obj_valid !== 1'b1) begin
            n_err++; $display("FAIL release_done at=%0d cnt=%0d v=%0b want at=3 cnt=1 v=1",
                              done_at, done_cnt, obj_valid);
        end
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (obs_pt[i] !== 10'(new_pt[i])) begin
                n_err++; $display("FAIL release_%s got %0d want %0d", pt_name[i], obs_pt[i], new_pt[i]);
            end
        end
        n_vec++;
        if (centre_pos_x !== 12'd203 || centre_pos_y !== 12'd203) begin
            n_err++; $display("FAIL release_centre got (%0d,%0d) want (203,203)", centre_pos_x, centre_pos_y);
        end
    endtask

    task automatic test_saturation();
        int exp_pt [8] = '{0, 0, 1023, 0, 0, 0, 1023, 0};
        int done_at, done_cnt;
        start_frame();
        send_line(4, 0);
        end_frame(done_at, done_cnt);
        n_vec++;
        if (done_at != 3 || done_cnt != 1 || obj_valid !== 1'b1) begin
            n_err++; $display("FAIL sat_done at=%0d cnt=%0d v=%0b want at=3 cnt=1 v=1",
                              done_at, done_cnt, obj_valid);
        end
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (obs_pt[i] !== 10'(exp_pt[i])) begin
                n_err++; $display("FAIL sat_%s got %0d want %0d", pt_name[i], obs_pt[i], exp_pt[i]);
            end
        end
        n_vec++;
        if (centre_pos_x !== 12'd511 || centre_pos_y !== 12'd0) begin
            n_err++; $display("FAIL sat_centre got (%0d,%0d) want (511,0)", centre_pos_x, centre_pos_y);
        end
    endtask

    task automatic test_midframe_reset();
        int done_at, done_cnt;
        start_frame();
        for (int y = 0; y < 240; y++) send_line(5, y);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); pix_hs = 1'b1; pix_de = 1'b1; pix_data = mk_data(i);
        end
        @(negedge clk); rst_n = 1'b0;
        #1;
        n_vec++;
        if (all_outs !== 106'd0) begin
            n_err++; $display("FAIL midreset_outs got %h want 0", all_outs);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); pix_hs = 1'b1; pix_de = 1'b1; pix_data = mk_data(i);
        end
        repeat (4) begin
            @(negedge clk); pix_hs = 1'b0; pix_de = 1'b0;
        end
        for (int y = 241; y < 261; y++) send_line(5, y);
        end_frame(done_at, done_cnt);
        n_vec++;
        if (done_cnt != 0 || all_outs !== 106'd0) begin
            n_err++; $display("FAIL partial_frame_ignored cnt=%0d outs=%h want cnt=0 outs=0",
                              done_cnt, all_outs);
        end
        test_square("after_reset");
    endtask

    initial begin
        test_reset();
        test_square("square");
        test_diamond();
        test_low_count();
        test_hold();
        test_saturation();
        test_midframe_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
